// File: rtl/spi_resp_slave_pkg.sv
// Shared types and defaults for the SPI response slave.
package spi_resp_slave_pkg;

    // Frame length used when the top is instantiated without an override.
    localparam int DEFAULT_WIDTH = 12;

    // Frame-level protocol state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/spi_resp_slave_if.sv
// SPI pins plus the local response/receive handshake of the slave.
interface spi_resp_slave_if
    import spi_resp_slave_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             sclk;
    logic             cs;
    logic             mosi;
    logic             miso;
    logic [WIDTH-1:0] tx_din;
    logic             tx_load;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_dout;
    logic             done;
    logic             abort;

    // Side that drives the SPI bus and loads responses.
    modport master (
        output sclk, cs, mosi, tx_din, tx_load,
        input  miso, tx_ready, rx_dout, done, abort
    );

    // The responding slave.
    modport slave (
        input  sclk, cs, mosi, tx_din, tx_load,
        output miso, tx_ready, rx_dout, done, abort
    );
endinterface

// File: rtl/spi_resp_slave_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, followed by a
// rise/fall detector working on the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              prev;

    // Shift the raw input through the chain and remember the last synced level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= {STAGES{INIT}};
            prev  <= INIT;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old
            // value of its neighbour, so the chain really delays by STAGES clocks.
            chain <= (chain << 1) | STAGES'(din);
            prev  <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~prev;
    assign fall = ~chain[STAGES-1] & prev;
endmodule

// File: rtl/spi_resp_slave.sv
// SPI slave that receives a WIDTH-bit word LSB first on mosi while
// returning a preloaded response word LSB first on miso. sclk is sampled
// as data in the clk domain; the master changes data on sclk rise and
// samples on sclk fall.
module spi_resp_slave
    import spi_resp_slave_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input logic             clk,
    input logic             rst,
    spi_resp_slave_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    logic                   sclk_rise, sclk_fall;
    logic                   cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   mosi_s;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       shift_rx;
    logic [WIDTH-1:0]       shift_tx;
    logic [WIDTH-1:0]       tx_buf;
    logic [WIDTH-1:0]       rx_dout_q;
    logic                   miso_q, done_q, abort_q, tx_ready_q;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.cs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // Level-only synchronizer for mosi; it is only sampled on sclk fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mosi_sync <= '0;
        else      mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(bus.mosi);
    end

    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Response buffer: writable only while no frame is in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           tx_buf <= '0;
        else if (bus.tx_load && tx_ready_q) tx_buf <= bus.tx_din;
    end

    // Frame FSM with registered outputs; cs rise takes priority over sclk edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shift_rx   <= '0;
            shift_tx   <= '0;
            rx_dout_q  <= '0;
            miso_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            tx_ready_q <= 1'b1;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state      <= ACTIVE;
                        cnt        <= '0;
                        shift_tx   <= tx_buf;
                        miso_q     <= tx_buf[0];
                        tx_ready_q <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        abort_q    <= 1'b1;
                        miso_q     <= 1'b0;
                        tx_ready_q <= 1'b1;
                    end else if (sclk_fall) begin
                        shift_rx <= {mosi_s, shift_rx[WIDTH-1:1]};
                        cnt      <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            rx_dout_q  <= {mosi_s, shift_rx[WIDTH-1:1]};
                            done_q     <= 1'b1;
                            state      <= HOLD;
                            miso_q     <= 1'b0;
                            tx_ready_q <= 1'b1;
                        end
                    end else if (sclk_rise && cnt != '0) begin
                        // The first rise precedes bit 0's sample, so bit 0 stays put.
                        shift_tx <= shift_tx >> 1;
                        miso_q   <= shift_tx[1];
                    end
                end
                HOLD: begin
                    miso_q <= 1'b0;
                    if (cs_rise) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    miso_q     <= 1'b0;
                    tx_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.miso     = miso_q;
    assign bus.done     = done_q;
    assign bus.abort    = abort_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_dout  = rx_dout_q;
endmodule

// File: tb/tb_spi_resp_slave.sv
// Bench for spi_resp_slave: a bit-banged SPI master plus a word-level
// model of what the slave should have received and returned.
module tb_spi_resp_slave;
    import spi_resp_slave_pkg::*;

    localparam int W    = 12;
    localparam int HALF = 6;   // sclk half-period in clk cycles

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_total = 0;
    int   abort_total = 0;

    logic [W-1:0] tx_model = '0;
    logic [W-1:0] rx_model = '0;

    spi_resp_slave_if #(.WIDTH(W)) bus ();

    spi_resp_slave #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Count clk cycles during which each pulse output is high.
    always @(negedge clk) begin
        if (bus.done === 1'b1)  done_total++;
        if (bus.abort === 1'b1) abort_total++;
    end

    task automatic load_tx(input logic [W-1:0] v);
        @(negedge clk);
        bus.tx_din  = v;
        bus.tx_load = 1'b1;
        @(negedge clk);
        bus.tx_load = 1'b0;
        tx_model    = v;   // only called while no frame is in progress
    endtask

    // Drive cs low, clock nbits bits, optionally release cs. miso is
    // sampled at the end of each high phase, just before the master's fall.
    task automatic spi_frame(input logic [W-1:0] data, input int nbits,
                             input bit end_cs, output logic [W-1:0] got);
        got = '0;
        @(negedge clk);
        bus.cs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = (i < W) ? data[i] : 1'($urandom);
            bus.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i < W) got[i] = bus.miso;
            bus.sclk = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        if (end_cs) begin
            bus.cs = 1'b1;
            repeat (2 * HALF) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++; if (bus.miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", bus.miso); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b expected 0", bus.abort); end
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", bus.tx_ready); end
        checks++; if (bus.rx_dout !== '0) begin errors++; $display("FAIL reset_rx_dout: got %h expected 000", bus.rx_dout); end
    endtask

    task automatic test_basic();
        logic [W-1:0] got;
        int d0, a0;
        load_tx(12'hA5C);
        d0 = done_total; a0 = abort_total;
        spi_frame(12'h3F1, W, 1'b0, got);
        rx_model = 12'h3F1;
        checks++; if (bus.miso !== 1'b0) begin errors++; $display("FAIL basic_hold_miso: got %b expected 0", bus.miso); end
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL basic_hold_ready: got %b expected 1", bus.tx_ready); end
        bus.cs = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        checks++; if (bus.rx_dout !== rx_model) begin errors++; $display("FAIL basic_rx: got %h expected %h", bus.rx_dout, rx_model); end
        checks++; if (got !== 12'hA5C) begin errors++; $display("FAIL basic_miso_word: got %h expected a5c", got); end
        checks++; if (done_total - d0 !== 1) begin errors++; $display("FAIL basic_done_cycles: got %0d expected 1", done_total - d0); end
        checks++; if (abort_total - a0 !== 0) begin errors++; $display("FAIL basic_abort_cycles: got %0d expected 0", abort_total - a0); end
        checks++; if (bus.miso !== 1'b0) begin errors++; $display("FAIL basic_idle_miso: got %b expected 0", bus.miso); end
    endtask

    task automatic test_abort();
        logic [W-1:0] got;
        int d0, a0;
        d0 = done_total; a0 = abort_total;
        spi_frame(12'hFFF, 5, 1'b1, got);
        checks++; if (abort_total - a0 !== 1) begin errors++; $display("FAIL abort_cycles: got %0d expected 1", abort_total - a0); end
        checks++; if (done_total - d0 !== 0) begin errors++; $display("FAIL abort_done_cycles: got %0d expected 0", done_total - d0); end
        checks++; if (bus.rx_dout !== rx_model) begin errors++; $display("FAIL abort_rx_kept: got %h expected %h", bus.rx_dout, rx_model); end
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL abort_idle_ready: got %b expected 1", bus.tx_ready); end
    endtask

    task automatic test_load_ignored();
        logic [W-1:0] got, got2, data;
        data = W'($urandom);
        fork
            spi_frame(data, W, 1'b1, got);
            begin
                repeat (40) @(negedge clk);
                checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL active_ready: got %b expected 0", bus.tx_ready); end
                bus.tx_din  = 12'h123;
                bus.tx_load = 1'b1;
                @(negedge clk);
                bus.tx_load = 1'b0;
            end
        join
        rx_model = data;
        checks++; if (got !== tx_model) begin errors++; $display("FAIL load_ign_miso1: got %h expected %h", got, tx_model); end
        spi_frame(12'h000, W, 1'b1, got2);
        rx_model = 12'h000;
        checks++; if (got2 !== tx_model) begin errors++; $display("FAIL load_ign_miso2: got %h expected %h", got2, tx_model); end
        checks++; if (bus.rx_dout !== rx_model) begin errors++; $display("FAIL load_ign_rx: got %h expected %h", bus.rx_dout, rx_model); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got, data;
        int d0;
        load_tx(12'h800);
        d0 = done_total;
        for (int f = 0; f < 2; f++) begin
            data = W'($urandom);
            spi_frame(data, W, 1'b1, got);
            rx_model = data;
            checks++; if (got !== 12'h800) begin errors++; $display("FAIL b2b_miso%0d: got %h expected 800", f, got); end
            checks++; if (bus.rx_dout !== rx_model) begin errors++; $display("FAIL b2b_rx%0d: got %h expected %h", f, bus.rx_dout, rx_model); end
        end
        checks++; if (done_total - d0 !== 2) begin errors++; $display("FAIL b2b_done_cycles: got %0d expected 2", done_total - d0); end
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] got;
        int d0, a0;
        spi_frame(12'h555, 7, 1'b0, got);
        d0 = done_total; a0 = abort_total;
        rst = 1'b0;
        #1;
        tx_model = '0;
        rx_model = '0;
        checks++; if (bus.miso !== 1'b0) begin errors++; $display("FAIL rstmid_miso: got %b expected 0", bus.miso); end
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", bus.tx_ready); end
        checks++; if (bus.rx_dout !== '0) begin errors++; $display("FAIL rstmid_rx: got %h expected 000", bus.rx_dout); end
        checks++; if (bus.done !== 1'b0 || bus.abort !== 1'b0) begin errors++; $display("FAIL rstmid_pulses: got done=%b abort=%b expected 0/0", bus.done, bus.abort); end
        bus.cs   = 1'b1;
        bus.sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (abort_total - a0 !== 0 || done_total - d0 !== 0) begin errors++; $display("FAIL rstmid_no_pulse: got abort=%0d done=%0d expected 0/0", abort_total - a0, done_total - d0); end
        spi_frame(12'h0AA, W, 1'b1, got);
        rx_model = 12'h0AA;
        checks++; if (bus.rx_dout !== rx_model) begin errors++; $display("FAIL rstmid_rx_after: got %h expected %h", bus.rx_dout, rx_model); end
        checks++; if (got !== tx_model) begin errors++; $display("FAIL rstmid_miso_after: got %h expected %h", got, tx_model); end
    endtask

    task automatic test_extra_edges();
        logic [W-1:0] got, data;
        int d0, a0;
        load_tx(W'($urandom));
        data = W'($urandom);
        d0 = done_total; a0 = abort_total;
        spi_frame(data, W + 2, 1'b1, got);
        rx_model = data;
        checks++; if (bus.rx_dout !== rx_model) begin errors++; $display("FAIL extra_rx: got %h expected %h", bus.rx_dout, rx_model); end
        checks++; if (got !== tx_model) begin errors++; $display("FAIL extra_miso: got %h expected %h", got, tx_model); end
        checks++; if (done_total - d0 !== 1 || abort_total - a0 !== 0) begin errors++; $display("FAIL extra_pulses: got done=%0d abort=%0d expected 1/0", done_total - d0, abort_total - a0); end
    endtask

    // Last sclk fall and cs rise land together: the bit must not count.
    task automatic test_simultaneous();
        logic [W-1:0] got;
        int d0, a0;
        d0 = done_total; a0 = abort_total;
        spi_frame(12'hFFF, W - 1, 1'b0, got);
        bus.mosi = 1'b1;
        bus.sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.sclk = 1'b0;
        bus.cs   = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        checks++; if (abort_total - a0 !== 1 || done_total - d0 !== 0) begin errors++; $display("FAIL simul_pulses: got abort=%0d done=%0d expected 1/0", abort_total - a0, done_total - d0); end
        checks++; if (bus.rx_dout !== rx_model) begin errors++; $display("FAIL simul_rx_kept: got %h expected %h", bus.rx_dout, rx_model); end
    endtask

    task automatic test_random();
        logic [W-1:0] got, data;
        int d0, a0, nbits;
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 1) == 1) load_tx(W'($urandom));
            data  = W'($urandom);
            nbits = $urandom_range(0, W + 2);
            d0 = done_total; a0 = abort_total;
            spi_frame(data, nbits, 1'b1, got);
            if (nbits >= W) begin
                rx_model = data;
                checks++; if (got !== tx_model) begin errors++; $display("FAIL rand%0d_miso: got %h expected %h", k, got, tx_model); end
            end
            checks++; if (bus.rx_dout !== rx_model) begin errors++; $display("FAIL rand%0d_rx: got %h expected %h", k, bus.rx_dout, rx_model); end
            checks++;
            if (done_total - d0 !== ((nbits >= W) ? 1 : 0) || abort_total - a0 !== ((nbits >= W) ? 0 : 1)) begin
                errors++;
                $display("FAIL rand%0d_pulses: got done=%0d abort=%0d for %0d bits", k, done_total - d0, abort_total - a0, nbits);
            end
        end
    endtask

    initial begin
        bus.sclk    = 1'b0;
        bus.cs      = 1'b1;
        bus.mosi    = 1'b0;
        bus.tx_din  = '0;
        bus.tx_load = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        test_reset();
        test_basic();
        test_abort();
        test_load_ignored();
        test_back_to_back();
        test_reset_mid_frame();
        test_extra_edges();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_resp_slave.md
SPI_RESP_SLAVE -- requirements
Module: spi_resp_slave

Interface
REQ-001 Parameter: WIDTH, 12, frame length in bits.
REQ-002 Parameter: SYNC_STAGES, 2, synchronizer flops per SPI input.
REQ-003 clk  input  1  system clock; sole clock of the block; sclk is treated as data.
REQ-004 rst  input  1  reset, asynchronous, active-low; asserted when 0.
REQ-005 sclk  input  1  SPI clock from master, asynchronous to clk.
REQ-006 cs  input  1  chip select, active-low, asynchronous to clk.
REQ-007 mosi  input  1  serial data from master, LSB first.
REQ-008 miso  output  1  serial response to master, LSB first.
REQ-009 tx_din  input  WIDTH  response word to transmit.
REQ-010 tx_load  input  1  capture tx_din when tx_ready=1.
REQ-011 tx_ready  output  1  response buffer may be loaded.
REQ-012 rx_dout  output  WIDTH  last complete received word.
REQ-013 done  output  1  one-clk pulse on frame completion.
REQ-014 abort  output  1  one-clk pulse when cs deasserts mid-frame.

Function
REQ-015 sclk, cs, mosi each pass through SYNC_STAGES flops; all decisions use synchronized copies only.
REQ-016 Edge detect: sclk rise/fall = synchronized sclk vs. its previous registered value; cs fall/rise likewise.
REQ-017 FSM states: IDLE, ACTIVE, HOLD.
REQ-018 IDLE: on cs fall -> ACTIVE; bit counter cleared to 0; shift_tx loaded from tx_buf; miso = tx_buf[0] from the next clk.
REQ-019 ACTIVE: on sclk fall, shift_rx <= {mosi_sync, shift_rx[WIDTH-1:1]}; counter increments.
REQ-020 ACTIVE: on sclk rise with counter >= 1, shift_tx shifts right by one; miso = shift_tx[0].
REQ-021 ACTIVE: when counter reaches WIDTH, on that same clk rx_dout <= completed word, done = 1 for exactly one clk, go to HOLD.
REQ-022 HOLD: further sclk edges ignored, miso = 0; cs rise -> IDLE.
REQ-023 ACTIVE: cs rise before counter = WIDTH -> abort = 1 for one clk, rx_dout unchanged, counter cleared, -> IDLE.
REQ-024 Simultaneous sclk fall and cs rise in ACTIVE: cs rise wins; bit not sampled; abort unless counter already WIDTH.
REQ-025 tx_ready = 1 in IDLE and HOLD, 0 in ACTIVE.
REQ-026 tx_load with tx_ready=1 -> tx_buf <= tx_din next clk; tx_load with tx_ready=0 ignored.
REQ-027 tx_buf persists across frames; an unreloaded buffer is retransmitted.
REQ-028 miso = 0 whenever state is IDLE.
REQ-029 Minimum sclk half-period: SYNC_STAGES+2 clk periods; faster sclk is unsupported.

Reset
REQ-030 rst=0 asynchronously forces: state IDLE, counter 0, shift registers 0, tx_buf 0, rx_dout 0, miso 0, done 0, abort 0, tx_ready 1, synchronizer flops to sclk=0/cs=1/mosi=0.
REQ-031 Reset mid-frame discards the partial word without an abort pulse; after release, a frame requires a fresh cs fall.

Structure
REQ-032 Shared package holds the state enum (IDLE, ACTIVE, HOLD) and the default WIDTH constant (12).
REQ-033 One sub-module: spi_sync_edge (parameterized synchronizer + rise/fall detector), instantiated for sclk and cs; mosi uses the synchronizer only.

Verification
REQ-034 Load tx_din=12'hA5C, master sends 12'h3F1 LSB first -> rx_dout=12'h3F1, one done pulse, miso bit sequence = 12'hA5C LSB first.
REQ-035 cs rises after 5 bits of 12'hFFF -> abort pulse, no done, rx_dout keeps prior value, state IDLE.
REQ-036 tx_load=1 with tx_din=12'h123 during ACTIVE -> ignored; next frame still transmits the previous tx_buf.
REQ-037 Two frames without reload, tx_buf=12'h800 -> both frames transmit 12'h800; done pulses twice.
REQ-038 rst=0 asserted after 7 bits -> all outputs at reset values immediately; subsequent full frame 12'h0AA received correctly.
REQ-039 14 sclk cycles while cs low -> done after bit 12; extra edges ignored; rx_dout = first 12 bits.
